// File: rtl/melody_sequencer.sv
// Square-wave melody player: steps through a (half_period, duration) note RAM,
// with a silent gap after each note, pause/resume, restart and loop support.
module melody_sequencer #(
  parameter int NUM_NOTES  = 32,
  parameter int PERIOD_W   = 20,
  parameter int DUR_W      = 28,
  parameter int GAP_CYCLES = 1_000_000,
  localparam int AW        = $clog2(NUM_NOTES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                play,
  input  logic                restart,
  input  logic                loop_en,
  input  logic [AW:0]         song_len,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [PERIOD_W-1:0] wr_half,
  input  logic [DUR_W-1:0]    wr_dur,
  output logic                melody,
  output logic                busy,
  output logic [AW-1:0]       note_idx,
  output logic                done
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [PERIOD_W-1:0] tone_q, tone_d;
  logic [PERIOD_W-1:0] half_q, half_d;
  logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic                mel_q, mel_d;
  logic                done_q, done_d;

  logic [PERIOD_W-1:0] half_mem [NUM_NOTES];
  logic [DUR_W-1:0]    dur_mem  [NUM_NOTES];

  logic                load;
  logic                advance;
  logic                last_entry;
  logic                wr_ok;
  logic [DUR_W-1:0]    dur_last;

  assign wr_ok      = {1'b0, wr_addr} < (AW+1)'(NUM_NOTES);
  assign dur_last   = (dur_q == '0) ? '0 : dur_q - DUR_W'(1);
  // idx+1 >= song_len also ends the song when song_len shrank below the current entry
  assign last_entry = ({1'b0, idx_q} + (AW+1)'(1)) >= song_len;

  // Loads read the pre-edge RAM contents, so a same-cycle write is seen on the next load
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      half_mem[wr_addr] <= wr_half;
      dur_mem[wr_addr]  <= wr_dur;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tone_d    = tone_q;
    dur_cnt_d = dur_cnt_q;
    gap_d     = gap_q;
    mel_d     = mel_q;
    half_d    = half_q;
    dur_d     = dur_q;
    done_d    = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;

    if (restart) begin
      idx_d     = '0;
      tone_d    = '0;
      dur_cnt_d = '0;
      gap_d     = '0;
      mel_d     = 1'b0;
      if (play) load = 1'b1;
      else      state_d = IDLE;
    end else if (play) begin
      unique case (state_q)
        IDLE: begin
          if (song_len != '0) load = 1'b1;
        end
        TONE: begin
          if (half_q != '0) begin
            if (tone_q == half_q - PERIOD_W'(1)) begin
              tone_d = '0;
              mel_d  = ~mel_q;
            end else begin
              tone_d = tone_q + PERIOD_W'(1);
            end
          end
          if (dur_cnt_q == dur_last) begin
            if (GAP_CYCLES != 0) begin
              state_d   = GAP;
              gap_d     = '0;
              tone_d    = '0;
              dur_cnt_d = '0;
              mel_d     = 1'b0;
            end else begin
              advance = 1'b1;
            end
          end else begin
            dur_cnt_d = dur_cnt_q + DUR_W'(1);
          end
        end
        GAP: begin
          if (gap_q == GW'(GAP_CYCLES - 1)) advance = 1'b1;
          else                              gap_d = gap_q + GW'(1);
        end
        default: state_d = IDLE;
      endcase
    end

    if (advance) begin
      if (!last_entry) begin
        idx_d = idx_q + AW'(1);
        load  = 1'b1;
      end else if (loop_en) begin
        idx_d = '0;
        load  = 1'b1;
      end else begin
        idx_d     = '0;
        done_d    = 1'b1;
        state_d   = IDLE;
        tone_d    = '0;
        dur_cnt_d = '0;
        gap_d     = '0;
        mel_d     = 1'b0;
      end
    end

    if (load) begin
      state_d   = TONE;
      tone_d    = '0;
      dur_cnt_d = '0;
      gap_d     = '0;
      mel_d     = 1'b0;
      if ({1'b0, idx_d} < (AW+1)'(NUM_NOTES)) begin
        half_d = half_mem[idx_d];
        dur_d  = dur_mem[idx_d];
      end else begin
        half_d = '0;
        dur_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      tone_q    <= '0;
      dur_cnt_q <= '0;
      gap_q     <= '0;
      mel_q     <= 1'b0;
      half_q    <= '0;
      dur_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tone_q    <= tone_d;
      dur_cnt_q <= dur_cnt_d;
      gap_q     <= gap_d;
      mel_q     <= mel_d;
      half_q    <= half_d;
      dur_q     <= dur_d;
      done_q    <= done_d;
    end
  end

  assign melody   = mel_q & play;
  assign busy     = (state_q != IDLE);
  assign note_idx = idx_q;
  assign done     = done_q;

endmodule
